// File: rtl/usb_nrzi_unstuff.sv
// Receive-side NRZI decoder with bit unstuffing, EOP detection and line-error flags.
// Ports:
//   clk, n_rst        - clock and synchronous active-low reset
//   d_plus, d_minus   - synchronised USB line inputs
//   shift_enable      - one-cycle bit-sample strobe
//   d_orig            - decoded data bit (held between valid bits)
//   bit_valid         - pulse: d_orig carries a real data bit
//   eop               - pulse: SE0 run of EOP_SE0_BITS or more, ended by J
//   stuff_err         - pulse: STUFF_LEN ones followed by another one
//   line_err          - pulse: SE1, or SE0 run ended by K or ended too early
module usb_nrzi_unstuff #(
  parameter int unsigned STUFF_LEN    = 6,
  parameter bit          IDLE_J       = 1'b1,
  parameter int unsigned EOP_SE0_BITS = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus,
  input  logic d_minus,
  input  logic shift_enable,
  output logic d_orig,
  output logic bit_valid,
  output logic eop,
  output logic stuff_err,
  output logic line_err
);

  localparam int unsigned OW = $clog2(STUFF_LEN + 1);
  localparam int unsigned SW = $clog2(EOP_SE0_BITS + 1);

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_SE0  = 1'b1
  } state_t;

  state_t        state, state_n;
  logic          prev_lvl, prev_lvl_n;
  logic [OW-1:0] ones_cnt, ones_cnt_n;
  logic [SW-1:0] se0_cnt, se0_cnt_n;
  logic          d_orig_n, bit_valid_n, eop_n, stuff_err_n, line_err_n;

  // Line level: 1 = J, 0 = K (only meaningful when the line is J or K)
  logic lvl, is_j, is_se0, is_se1, bit_c;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= ST_DATA;
      prev_lvl  <= IDLE_J;
      ones_cnt  <= '0;
      se0_cnt   <= '0;
      d_orig    <= 1'b1;
      bit_valid <= 1'b0;
      eop       <= 1'b0;
      stuff_err <= 1'b0;
      line_err  <= 1'b0;
    end else begin
      state     <= state_n;
      prev_lvl  <= prev_lvl_n;
      ones_cnt  <= ones_cnt_n;
      se0_cnt   <= se0_cnt_n;
      d_orig    <= d_orig_n;
      bit_valid <= bit_valid_n;
      eop       <= eop_n;
      stuff_err <= stuff_err_n;
      line_err  <= line_err_n;
    end
  end

  // Next-state, decode and pulse generation
  always_comb begin
    state_n     = state;
    prev_lvl_n  = prev_lvl;
    ones_cnt_n  = ones_cnt;
    se0_cnt_n   = se0_cnt;
    d_orig_n    = d_orig;
    bit_valid_n = 1'b0;
    eop_n       = 1'b0;
    stuff_err_n = 1'b0;
    line_err_n  = 1'b0;

    lvl    = d_plus;
    is_j   = d_plus & ~d_minus;
    is_se0 = ~d_plus & ~d_minus;
    is_se1 = d_plus & d_minus;
    bit_c  = (lvl == prev_lvl);

    if (shift_enable) begin
      if (is_se1) begin
        // Illegal line state: flag it and leave all decode state untouched
        line_err_n = 1'b1;
      end else begin
        case (state)
          ST_DATA: begin
            if (is_se0) begin
              se0_cnt_n  = SW'(1);
              ones_cnt_n = '0;
              state_n    = ST_SE0;
            end else begin
              prev_lvl_n = lvl;
              if (ones_cnt < OW'(STUFF_LEN)) begin
                d_orig_n    = bit_c;
                bit_valid_n = 1'b1;
                ones_cnt_n  = bit_c ? (ones_cnt + OW'(1)) : '0;
              end else begin
                // Slot after a full run of ones must be a stuffed zero
                ones_cnt_n  = '0;
                stuff_err_n = bit_c;
              end
            end
          end
          ST_SE0: begin
            if (is_se0) begin
              if (se0_cnt < SW'(EOP_SE0_BITS)) begin
                se0_cnt_n = se0_cnt + SW'(1);
              end
            end else begin
              if (is_j && (se0_cnt >= SW'(EOP_SE0_BITS))) begin
                eop_n = 1'b1;
              end else begin
                line_err_n = 1'b1;
              end
              prev_lvl_n = is_j;
              se0_cnt_n  = '0;
              state_n    = ST_DATA;
            end
          end
          default: state_n = ST_DATA;
        endcase
      end
    end
  end

endmodule
